// File: rtl/alu_retire_stage_pkg.sv
// Shared constants for the ALU retire stage: ARM condition encodings,
// NZCV bit positions and the retire-queue occupancy states.
// No logic; imported by the stage top and the condition checker.
package alu_retire_stage_pkg;

    // ARM 4-bit condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    // Bit positions inside the {N,Z,C,V} flag vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Retire-queue occupancy; the encoding equals the entry count
    typedef enum logic [1:0] {
        Q_EMPTY = 2'd0,
        Q_ONE   = 2'd1,
        Q_FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/alu_retire_stage_if.sv
// Handshake bundle between the ALU, the retire stage and register writeback.
// Latency: none (wires only).
// Backpressure: in_ready / out_ready carried alongside their valids.
// master = ALU + writeback side (drives in_*, out_ready);
// slave  = retire stage (drives in_ready, cond_pass, out_*, flags_nzcv).
interface alu_retire_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  in_n;
    logic                  in_z;
    logic                  in_c;
    logic                  in_v;
    logic [3:0]            in_cond;
    logic                  in_set_flags;
    logic                  in_wr_en;
    logic [RD_WIDTH-1:0]   in_rd;
    logic                  cond_pass;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [RD_WIDTH-1:0]   out_rd;
    logic                  out_wr_en;
    logic [3:0]            flags_nzcv;

    modport master (
        output in_valid, in_result, in_n, in_z, in_c, in_v, in_cond,
               in_set_flags, in_wr_en, in_rd, out_ready,
        input  in_ready, cond_pass, out_valid, out_result, out_rd,
               out_wr_en, flags_nzcv
    );

    modport slave (
        input  in_valid, in_result, in_n, in_z, in_c, in_v, in_cond,
               in_set_flags, in_wr_en, in_rd, out_ready,
        output in_ready, cond_pass, out_valid, out_result, out_rd,
               out_wr_en, flags_nzcv
    );

endinterface

// File: rtl/alu_retire_stage_arm_cond_check.sv
// Evaluates an ARM condition field against an NZCV flag vector.
// Latency: purely combinational.
// Backpressure: none.
// Ports: cond_i[3:0] condition field, nzcv_i[3:0] flags {N,Z,C,V}, pass_o result.
module arm_cond_check
    import alu_retire_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;   // never-execute space: always annul
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_retire_stage.sv
// Execute-to-writeback stage: condition check, NZCV update, 2-entry in-order retire queue.
// Latency: accepted instruction appears at out_valid the next cycle when the queue is empty.
// Backpressure: in_ready drops when both slots are occupied (from registered count only).
// Ports: clk, nreset (async active-low); bus (slave modport) carries the ALU input
// handshake, cond_pass, the writeback output handshake and flags_nzcv.
module alu_retire_stage
    import alu_retire_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_WIDTH   = 4
) (
    input  logic                clk,
    input  logic                nreset,
    alu_retire_stage_if.slave   bus
);

    q_state_e              state_q;
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [DATA_WIDTH-1:0] res_q [2];
    logic [RD_WIDTH-1:0]   rd_q  [2];
    logic [1:0]            wen_q;
    logic [3:0]            nzcv_q;
    logic [3:0]            nzcv_d;

    logic push;
    logic pop;
    logic pass;

    // Checked against the registered flags only: a flag-setting instruction
    // affects the condition of the instruction accepted one cycle later.
    arm_cond_check u_cond (
        .cond_i (bus.in_cond),
        .nzcv_i (nzcv_q),
        .pass_o (pass)
    );

    assign bus.cond_pass  = pass;
    assign bus.in_ready   = (state_q != Q_FULL);
    assign bus.out_valid  = (state_q != Q_EMPTY);
    assign bus.out_result = res_q[rd_ptr_q];
    assign bus.out_rd     = rd_q[rd_ptr_q];
    assign bus.out_wr_en  = wen_q[rd_ptr_q];
    assign bus.flags_nzcv = nzcv_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_comb begin
        nzcv_d = nzcv_q;
        if (push && pass && bus.in_set_flags) begin
            nzcv_d = {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            nzcv_q <= 4'b0000;
        end else begin
            nzcv_q <= nzcv_d;
        end
    end

    // Occupancy FSM plus the wrapping 1-bit slot pointers.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q  <= Q_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            case (state_q)
                Q_EMPTY: begin
                    if (push) state_q <= Q_ONE;
                end
                Q_ONE: begin
                    if (push && !pop)      state_q <= Q_FULL;
                    else if (pop && !push) state_q <= Q_EMPTY;
                end
                Q_FULL: begin
                    // push cannot happen here since in_ready is low
                    if (pop) state_q <= Q_ONE;
                end
                default: state_q <= Q_EMPTY;
            endcase
        end
    end

    // Slot storage; annulled instructions still take a slot so that
    // retire order always matches issue order.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i] <= '0;
                rd_q[i]  <= '0;
            end
            wen_q <= 2'b00;
        end else if (push) begin
            res_q[wr_ptr_q] <= bus.in_result;
            rd_q[wr_ptr_q]  <= bus.in_rd;
            wen_q[wr_ptr_q] <= bus.in_wr_en && pass;
        end
    end

endmodule
